// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the NN_CORE training sequencer.
// Values are signed Q2.14 throughout; the sequencer never interprets them.
package nn_pkg;

    localparam int unsigned NN_DATA_W        = 16;
    localparam int unsigned NN_SAMPLE_CYCLES = 13;

    localparam logic [NN_DATA_W-1:0] NN_Q_ONE  = 16'h4000;
    localparam logic [NN_DATA_W-1:0] NN_Q_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        StIdle,
        StCoreRst,
        StTrain,
        StInfer,
        StDone
    } nn_state_e;

    function automatic int unsigned nn_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nn_sample_regfile.sv
// N x (2*WIDTH) register file: one synchronous write port, one asynchronous read port.
// Cleared by the synchronous active-low reset; out-of-range addresses write nothing, read 0.
module nn_sample_regfile #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic                 i_clk,
    input  logic                 i_res,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_addr,
    input  logic [2*WIDTH-1:0]   i_wr_data,
    input  logic [IDX_W-1:0]     i_rd_addr,
    output logic [2*WIDTH-1:0]   o_rd_data
);

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic               w_wr_ok;
    logic               w_rd_ok;

    assign w_wr_ok = i_wr_en && (32'(i_wr_addr) < DEPTH);
    assign w_rd_ok = 32'(i_rd_addr) < DEPTH;

    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = w_rd_ok ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/nn_train_sequencer.sv
// Drives NN_CORE through reset, repeated training epochs over the stored samples,
// and a final inference pass whose outputs are captured per sample for the host.
module nn_train_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W        = NN_DATA_W,
    parameter int unsigned N_SAMPLES     = 4,
    parameter int unsigned IDX_W         = 2,
    parameter int unsigned SAMPLE_CYCLES = NN_SAMPLE_CYCLES,
    parameter int unsigned RST_CYCLES    = 1,
    parameter int unsigned EPOCH_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_res,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [EPOCH_W-1:0] i_max_epochs,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0]  i_wr_x1,
    input  logic [DATA_W-1:0]  i_wr_x2,
    input  logic [IDX_W-1:0]   i_rd_addr,
    output logic [DATA_W-1:0]  o_rd_y1,
    output logic [DATA_W-1:0]  o_rd_y2,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout,
    output logic [EPOCH_W-1:0] o_epoch_count,
    output logic               o_core_res,
    output logic               o_core_update_coeff,
    output logic [DATA_W-1:0]  o_core_input_k_1,
    output logic [DATA_W-1:0]  o_core_input_k_2,
    input  logic               i_core_finish_updating,
    input  logic [DATA_W-1:0]  i_core_a3_1,
    input  logic [DATA_W-1:0]  i_core_a3_2
);

    localparam int unsigned CNT_MAX = nn_max(SAMPLE_CYCLES, RST_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    nn_state_e          r_state;
    nn_state_e          w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [EPOCH_W-1:0] r_epoch;
    logic [EPOCH_W-1:0] r_limit;
    logic               r_timeout;
    logic               r_fin;

    logic               w_start_ok;
    logic               w_win_end;
    logic               w_rst_end;
    logic               w_last_idx;
    logic               w_fin_any;
    logic               w_limit_hit;
    logic [EPOCH_W:0]   w_epoch_inc;
    logic               w_smp_we;
    logic               w_res_we;
    logic [2*DATA_W-1:0] w_smp_rd;
    logic [2*DATA_W-1:0] w_res_rd;

    assign w_start_ok  = i_start && !i_abort;
    assign w_win_end   = r_cnt == CNT_W'(SAMPLE_CYCLES - 1);
    assign w_rst_end   = r_cnt == CNT_W'(RST_CYCLES - 1);
    assign w_last_idx  = r_idx == IDX_W'(N_SAMPLES - 1);
    assign w_fin_any   = r_fin || i_core_finish_updating;
    // One bit wider so a limit at the counter's maximum still compares correctly.
    assign w_epoch_inc = {1'b0, r_epoch} + {{EPOCH_W{1'b0}}, 1'b1};
    assign w_limit_hit = w_epoch_inc == {1'b0, r_limit};

    assign w_smp_we = i_wr_en && (r_state == StIdle);
    assign w_res_we = (r_state == StInfer) && w_win_end && !i_abort;

    nn_sample_regfile #(
        .WIDTH (DATA_W),
        .DEPTH (N_SAMPLES),
        .IDX_W (IDX_W)
    ) u_samples (
        .i_clk     (i_clk),
        .i_res     (i_res),
        .i_wr_en   (w_smp_we),
        .i_wr_addr (i_wr_addr),
        .i_wr_data ({i_wr_x1, i_wr_x2}),
        .i_rd_addr (r_idx),
        .o_rd_data (w_smp_rd)
    );

    nn_sample_regfile #(
        .WIDTH (DATA_W),
        .DEPTH (N_SAMPLES),
        .IDX_W (IDX_W)
    ) u_results (
        .i_clk     (i_clk),
        .i_res     (i_res),
        .i_wr_en   (w_res_we),
        .i_wr_addr (r_idx),
        .i_wr_data ({i_core_a3_1, i_core_a3_2}),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (w_res_rd)
    );

    assign o_rd_y1       = w_res_rd[2*DATA_W-1:DATA_W];
    assign o_rd_y2       = w_res_rd[DATA_W-1:0];
    assign o_timeout     = r_timeout;
    assign o_epoch_count = r_epoch;

    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        o_core_res          = 1'b1;
        o_core_update_coeff = 1'b0;
        o_busy              = 1'b0;
        o_done              = 1'b0;
        o_core_input_k_1    = NN_Q_ZERO;
        o_core_input_k_2    = NN_Q_ZERO;
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) w_state_next = StCoreRst;
            end
            StCoreRst: begin
                o_busy = 1'b1;
                if (w_rst_end) w_state_next = StTrain;
            end
            StTrain: begin
                o_busy              = 1'b1;
                o_core_res          = 1'b0;
                o_core_update_coeff = 1'b1;
                o_core_input_k_1    = w_smp_rd[2*DATA_W-1:DATA_W];
                o_core_input_k_2    = w_smp_rd[DATA_W-1:0];
                if (w_win_end && w_last_idx && (w_fin_any || w_limit_hit)) begin
                    w_state_next = StInfer;
                end
            end
            StInfer: begin
                o_busy           = 1'b1;
                o_core_res       = 1'b0;
                o_core_input_k_1 = w_smp_rd[2*DATA_W-1:DATA_W];
                o_core_input_k_2 = w_smp_rd[DATA_W-1:0];
                if (w_win_end && w_last_idx) w_state_next = StDone;
            end
            StDone: begin
                o_core_res   = 1'b0;
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        if (i_abort) w_state_next = StIdle;
    end

    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_epoch   <= '0;
            r_limit   <= '0;
            r_timeout <= 1'b0;
            r_fin     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_start_ok) begin
                        r_limit   <= (i_max_epochs == '0) ? EPOCH_W'(1) : i_max_epochs;
                        r_epoch   <= '0;
                        r_timeout <= 1'b0;
                        r_fin     <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                StCoreRst: begin
                    if (w_rst_end) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StTrain: begin
                    if (i_core_finish_updating) r_fin <= 1'b1;
                    if (w_win_end) begin
                        r_cnt <= '0;
                        r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
                        if (w_last_idx) begin
                            if (r_epoch != '1) r_epoch <= r_epoch + EPOCH_W'(1);
                            // finish_updating outranks the epoch limit
                            if (!w_fin_any && w_limit_hit) r_timeout <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StInfer: begin
                    if (w_win_end) begin
                        r_cnt <= '0;
                        r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StDone: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_train_sequencer.sv
// Bench for nn_train_sequencer with a stub NN_CORE; expected per-sample results are
// queued at each session start and compared once the session reports done.
module tb_nn_train_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned NS = 2;
    localparam int unsigned IW = 1;
    localparam int unsigned EW = 16;

    typedef struct packed {
        logic [DW-1:0] y1;
        logic [DW-1:0] y2;
    } exp_t;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [EW-1:0] max_epochs = '0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_x1 = '0;
    logic [DW-1:0] wr_x2 = '0;
    logic [IW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_y1, rd_y2;
    logic          busy, done, timeout;
    logic [EW-1:0] epoch_count;
    logic          core_res, core_upd;
    logic [DW-1:0] core_in1, core_in2;
    logic          core_fin = 1'b0;
    logic [DW-1:0] core_a3_1, core_a3_2;

    logic [DW-1:0] smp_x1 [NS];
    logic [DW-1:0] smp_x2 [NS];
    exp_t          sb [$];
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    nn_train_sequencer #(
        .DATA_W        (DW),
        .N_SAMPLES     (NS),
        .IDX_W         (IW),
        .SAMPLE_CYCLES (13),
        .RST_CYCLES    (1),
        .EPOCH_W       (EW)
    ) dut (
        .i_clk                  (clk),
        .i_res                  (res),
        .i_start                (start),
        .i_abort                (abort),
        .i_max_epochs           (max_epochs),
        .i_wr_en                (wr_en),
        .i_wr_addr              (wr_addr),
        .i_wr_x1                (wr_x1),
        .i_wr_x2                (wr_x2),
        .i_rd_addr              (rd_addr),
        .o_rd_y1                (rd_y1),
        .o_rd_y2                (rd_y2),
        .o_busy                 (busy),
        .o_done                 (done),
        .o_timeout              (timeout),
        .o_epoch_count          (epoch_count),
        .o_core_res             (core_res),
        .o_core_update_coeff    (core_upd),
        .o_core_input_k_1       (core_in1),
        .o_core_input_k_2       (core_in2),
        .i_core_finish_updating (core_fin),
        .i_core_a3_1            (core_a3_1),
        .i_core_a3_2            (core_a3_2)
    );

    // Stub core: a3_1 tags which sample is presented, a3_2 mixes both inputs.
    always_comb begin
        core_a3_1 = (core_in1 == 16'hE000) ? 16'h1235 : 16'h1234;
        core_a3_2 = core_in1 ^ ~core_in2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_samples();
        smp_x1[0] = 16'h2000;
        smp_x2[0] = 16'h2000;
        smp_x1[1] = 16'hE000;
        smp_x2[1] = 16'h2000;
        for (int i = 0; i < NS; i++) begin
            wr_en   = 1'b1;
            wr_addr = IW'(i);
            wr_x1   = smp_x1[i];
            wr_x2   = smp_x2[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic run_session(input logic [EW-1:0] max_e, input int fin_at, input int intf_at,
                               input int exp_lat, input int exp_ep, input logic exp_to);
        int   cnt;
        exp_t e;
        for (int i = 0; i < NS; i++) begin
            e.y1 = 16'h1234 + DW'(i);
            e.y2 = smp_x1[i] ^ ~smp_x2[i];
            sb.push_back(e);
        end
        max_epochs = max_e;
        start      = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 1;
        while (!done && cnt < 1000) begin
            if (cnt == 2) begin
                check("train_upd", 32'(core_upd), 32'd1);
                check("train_core_res", 32'(core_res), 32'd0);
                check("train_in1", 32'(core_in1), 32'(smp_x1[0]));
            end
            core_fin = (cnt == fin_at);
            if (cnt == intf_at) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_x1   = 16'h7777;
                start   = 1'b1;
            end
            tick();
            core_fin = 1'b0;
            wr_en    = 1'b0;
            start    = 1'b0;
            cnt++;
        end
        check("latency", 32'(cnt), 32'(exp_lat));
        check("done_high", 32'(done), 32'd1);
        check("epoch_count", 32'(epoch_count), 32'(exp_ep));
        check("timeout", 32'(timeout), 32'(exp_to));
        tick();
        check("done_pulse_end", 32'(done), 32'd0);
        check("idle_core_res", 32'(core_res), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NS; i++) begin
            e       = sb.pop_front();
            rd_addr = IW'(i);
            #1;
            check("rd_y1", 32'(rd_y1), 32'(e.y1));
            check("rd_y2", 32'(rd_y2), 32'(e.y2));
        end
    endtask

    initial begin
        int seen_done;

        res = 1'b0;
        repeat (3) tick();
        check("rst_core_res", 32'(core_res), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_epoch", 32'(epoch_count), 32'd0);
        check("rst_rd_y1", 32'(rd_y1), 32'd0);
        check("rst_rd_y2", 32'(rd_y2), 32'd0);
        res = 1'b1;
        tick();

        load_samples();
        // Epoch limit, with start and sample write attempted mid-session.
        run_session(16'd3, -1, 10, 106, 3, 1'b1);
        // finish_updating pulsed mid-window in epoch 2.
        run_session(16'd3, 35, -1, 80, 2, 1'b0);

        // Abort 40 cycles into TRAIN.
        max_epochs = 16'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (41) tick();
        check("pre_abort_upd", 32'(core_upd), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_upd", 32'(core_upd), 32'd0);
        check("abort_core_res", 32'(core_res), 32'd1);
        check("abort_epoch_kept", 32'(epoch_count), 32'd1);
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) seen_done++;
            tick();
        end
        check("abort_no_done", 32'(seen_done), 32'd0);

        // abort beats start in the same cycle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_over_start", 32'(busy), 32'd0);

        // Reset during INFER.
        max_epochs = 16'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        res = 1'b0;
        tick();
        res     = 1'b1;
        rd_addr = '0;
        #1;
        check("mid_rst_core_res", 32'(core_res), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_epoch", 32'(epoch_count), 32'd0);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        check("mid_rst_in1", 32'(core_in1), 32'd0);
        check("mid_rst_rd_y1", 32'(rd_y1), 32'd0);
        tick();

        load_samples();
        // max_epochs of 0 behaves as a single epoch.
        run_session(16'd0, -1, -1, 54, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
